// File: rtl/cpu_control.sv
// Multi-cycle control FSM for a tiny 8-bit, 4-register CPU: fetch, decode,
// ALU execute, optional load-immediate, halt. All outputs are Moore.
// Ports: clk, reset_n (async, active low); pc_in; imem_req/addr, imem_ack/data;
// rf_read_addr1/2, rf_read_data1/2; rf_write_enable/addr/data;
// rf_pc_write_enable; halted.
// Build option: CTRL_LDI_EN enables LDI (IMM/IMM_WB states).
module cpu_control (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] pc_in,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic [1:0] rf_read_addr1,
  output logic [1:0] rf_read_addr2,
  input  logic [7:0] rf_read_data1,
  input  logic [7:0] rf_read_data2,
  output logic       rf_write_enable,
  output logic [1:0] rf_write_addr,
  output logic [7:0] rf_write_data,
  output logic       rf_pc_write_enable,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_EXEC,
`ifdef CTRL_LDI_EN
    S_IMM,
    S_IMM_WB,
`endif
    S_HALT
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] ir;
  logic [7:0] alu;

  logic [3:0] op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic       is_hlt;
  logic       is_ldi;
  logic       is_alu;

  assign op = ir[7:4];
  assign rd = ir[3:2];
  assign rs = ir[1:0];

  assign is_hlt = (op == 4'hF);
`ifdef CTRL_LDI_EN
  assign is_ldi = (op == 4'h7);
`else
  assign is_ldi = 1'b0;
`endif
  assign is_alu = (op >= 4'h1 && op <= 4'h6)
               || (op == 4'h8);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_START;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && imem_ack)
        ir <= imem_data;
    end
  end

`ifdef CTRL_LDI_EN
  logic [7:0] imm;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      imm <= '0;
    else if (state == S_IMM && imem_ack)
      imm <= imem_data;
  end
`endif

  // Carry/borrow simply fall off the 8-bit result.
  always_comb begin
    alu = '0;
    unique case (op)
      4'h1:    alu = rf_read_data1 + rf_read_data2;
      4'h2:    alu = rf_read_data1 - rf_read_data2;
      4'h3:    alu = rf_read_data1 & rf_read_data2;
      4'h4:    alu = rf_read_data1 | rf_read_data2;
      4'h5:    alu = rf_read_data1 ^ rf_read_data2;
      4'h6:    alu = rf_read_data2;
      4'h8:    alu = rf_read_data1 + 8'd1;
      default: alu = '0;
    endcase
  end

  always_comb begin
    state_nxt          = state;
    imem_req           = 1'b0;
    imem_addr          = '0;
    rf_read_addr1      = '0;
    rf_read_addr2      = '0;
    rf_write_enable    = 1'b0;
    rf_write_addr      = '0;
    rf_write_data      = '0;
    rf_pc_write_enable = 1'b0;
    halted             = 1'b0;
    unique case (state)
      S_START: state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_in;
        if (imem_ack)
          state_nxt = S_DECODE;
      end
      S_DECODE: begin
        rf_pc_write_enable = 1'b1;
        rf_read_addr1      = rd;
        rf_read_addr2      = rs;
        unique case (1'b1)
          is_hlt:  state_nxt = S_HALT;
`ifdef CTRL_LDI_EN
          is_ldi:  state_nxt = S_IMM;
`endif
          is_alu:  state_nxt = S_EXEC;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_EXEC: begin
        rf_read_addr1   = rd;
        rf_read_addr2   = rs;
        rf_write_enable = 1'b1;
        rf_write_addr   = rd;
        rf_write_data   = alu;
        state_nxt       = S_FETCH;
      end
`ifdef CTRL_LDI_EN
      S_IMM: begin
        // PC was already bumped in DECODE.
        imem_req  = 1'b1;
        imem_addr = pc_in;
        if (imem_ack)
          state_nxt = S_IMM_WB;
      end
      S_IMM_WB: begin
        rf_write_enable    = 1'b1;
        rf_write_addr      = rd;
        rf_write_data      = imm;
        rf_pc_write_enable = 1'b1;
        state_nxt          = S_FETCH;
      end
`endif
      S_HALT:  halted    = 1'b1;
      default: state_nxt = S_START;
    endcase
  end

  logic unused_ldi;
  assign unused_ldi = is_ldi;

endmodule

// File: tb/tb_cpu_control.sv
// Bench for cpu_control: ISA-level reference model drives expected outputs
// per cycle; a single compare process checks them.
module tb_cpu_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] pc_in;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [1:0] rf_read_addr1;
  logic [1:0] rf_read_addr2;
  logic [7:0] rf_read_data1;
  logic [7:0] rf_read_data2;
  logic       rf_write_enable;
  logic [1:0] rf_write_addr;
  logic [7:0] rf_write_data;
  logic       rf_pc_write_enable;
  logic       halted;

  always #5 clk = ~clk;

  cpu_control dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .pc_in              (pc_in),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_ack           (imem_ack),
    .imem_data          (imem_data),
    .rf_read_addr1      (rf_read_addr1),
    .rf_read_addr2      (rf_read_addr2),
    .rf_read_data1      (rf_read_data1),
    .rf_read_data2      (rf_read_data2),
    .rf_write_enable    (rf_write_enable),
    .rf_write_addr      (rf_write_addr),
    .rf_write_data      (rf_write_data),
    .rf_pc_write_enable (rf_pc_write_enable),
    .halted             (halted)
  );

  // Environment: memory, register file and PC the controller drives.
  logic [7:0] mem [256];
  logic [7:0] seed [4];
  logic [7:0] env_regs [4];
  logic [7:0] env_pc;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      env_pc <= 8'h00;
      for (int i = 0; i < 4; i++)
        env_regs[i] <= seed[i];
    end else begin
      if (rf_write_enable)
        env_regs[rf_write_addr] <= rf_write_data;
      if (rf_pc_write_enable)
        env_pc <= env_pc + 8'd1;
    end
  end

  assign pc_in         = env_pc;
  assign imem_data     = mem[imem_addr];
  assign rf_read_data1 = env_regs[rf_read_addr1];
  assign rf_read_data2 = env_regs[rf_read_addr2];

  // Compare process.
  localparam logic [25:0] ZERO  = 26'h0;
  localparam logic [25:0] HLT_V = 26'h1;

  logic [25:0] exp_v = ZERO;
  logic [25:0] act_v;
  logic        chk_en = 1'b0;
  int          async_seq = 0;
  int          lit_seq = 0;
  int          lit_seen = 0;
  string       lit_name = "";
  logic [7:0]  lit_got = 8'h0;
  logic [7:0]  lit_want = 8'h0;
  int          checks = 0;
  int          errors = 0;

  assign act_v = {imem_req, imem_addr,
                  rf_read_addr1, rf_read_addr2,
                  rf_write_enable, rf_write_addr,
                  rf_write_data, rf_pc_write_enable,
                  halted};

  always @(negedge clk or async_seq or lit_seq) begin
    if (lit_seq != lit_seen) begin
      lit_seen = lit_seq;
      checks++;
      if (lit_got !== lit_want) begin
        errors++;
        $display("FAIL %s got %h want %h",
                 lit_name, lit_got, lit_want);
      end
    end else if (chk_en) begin
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t got %h want %h",
                 $time, act_v, exp_v);
      end
    end
  end

  // Reference model: ISA-level state plus expected per-cycle outputs.
  logic [7:0] m_regs [4];
  logic [7:0] m_pc;
  bit         ack_always;

  function automatic logic [25:0] pk(
    input logic       rq,
    input logic [7:0] ad,
    input logic [1:0] a1,
    input logic [1:0] a2,
    input logic       we,
    input logic [1:0] wa,
    input logic [7:0] wd,
    input logic       pw,
    input logic       h);
    return {rq, ad, a1, a2, we, wa, wd, pw, h};
  endfunction

  function automatic bit rnd_ack();
    return ($urandom_range(0, 1) == 1);
  endfunction

  task automatic cyc(input logic [25:0] e, input bit ack);
    exp_v    = e;
    imem_ack = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic mfetch(output logic [7:0] b);
    int w;
    bit a;
    w = 0;
    do begin
      a = ack_always || (w >= 4) || ($urandom_range(0, 2) == 0);
      cyc(pk(1'b1, m_pc, 2'd0, 2'd0, 1'b0, 2'd0, 8'h0, 1'b0, 1'b0), a);
      w++;
    end while (!a);
    b = mem[m_pc];
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    exp_v    = ZERO;
    imem_ack = 1'b0;
    #1;
    chk_en = 1'b1;
    async_seq++;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_regs  = seed;
    m_pc    = 8'h00;
    cyc(ZERO, rnd_ack());
  endtask

  // Returns 0 = continue, 1 = halted, 2 = reset taken in EXEC.
  task automatic minstr(input bit arm, output int code);
    logic [7:0] ir;
    logic [7:0] r;
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    code = 0;
    mfetch(ir);
    op = ir[7:4];
    rd = ir[3:2];
    rs = ir[1:0];
    cyc(pk(1'b0, 8'h0, rd, rs, 1'b0, 2'd0, 8'h0, 1'b1, 1'b0), rnd_ack());
    m_pc = m_pc + 8'd1;
    if (op == 4'hF) begin
      code = 1;
      return;
    end
    if ((op >= 4'h1 && op <= 4'h6) || op == 4'h8) begin
      case (op)
        4'h1:    r = m_regs[rd] + m_regs[rs];
        4'h2:    r = m_regs[rd] - m_regs[rs];
        4'h3:    r = m_regs[rd] & m_regs[rs];
        4'h4:    r = m_regs[rd] | m_regs[rs];
        4'h5:    r = m_regs[rd] ^ m_regs[rs];
        4'h6:    r = m_regs[rs];
        default: r = m_regs[rd] + 8'd1;
      endcase
      if (arm) begin
        exp_v    = pk(1'b0, 8'h0, rd, rs, 1'b1, rd, r, 1'b0, 1'b0);
        imem_ack = rnd_ack();
        async_seq++;
        #1;
        reset_n = 1'b0;
        exp_v   = ZERO;
        #1;
        async_seq++;
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_regs  = seed;
        m_pc    = 8'h00;
        cyc(ZERO, rnd_ack());
        code = 2;
        return;
      end
      cyc(pk(1'b0, 8'h0, rd, rs, 1'b1, rd, r, 1'b0, 1'b0), rnd_ack());
      m_regs[rd] = r;
    end
`ifdef CTRL_LDI_EN
    else if (op == 4'h7) begin
      mfetch(r);
      cyc(pk(1'b0, 8'h0, 2'd0, 2'd0, 1'b1, rd, r, 1'b1, 1'b0), rnd_ack());
      m_regs[rd] = r;
      m_pc = m_pc + 8'd1;
    end
`endif
  endtask

  task automatic lit(input string nm,
                     input logic [7:0] got,
                     input logic [7:0] want);
    cyc(HLT_V, rnd_ack());
    lit_name = nm;
    lit_got  = got;
    lit_want = want;
    lit_seq++;
  endtask

  initial begin
    int code;
    int n;
    int rst_at;
    reset_n    = 1'b1;
    imem_ack   = 1'b0;
    ack_always = 1'b1;

    // Directed program: ADD R0,R1 ; LDI R1,0x5A ; HLT
    for (int i = 0; i < 256; i++)
      mem[i] = 8'h00;
    mem[0]  = 8'h11;
    mem[1]  = 8'h74;
    mem[2]  = 8'h5A;
    mem[3]  = 8'hF0;
    seed[0] = 8'hF0;
    seed[1] = 8'h20;
    seed[2] = 8'h33;
    seed[3] = 8'h44;
    #2;
    do_reset();
    code = 0;
    n    = 0;
    while (code == 0 && n < 10) begin
      minstr(1'b0, code);
      n++;
    end
    repeat (20) cyc(HLT_V, rnd_ack());
    lit("r0_add_wrap", env_regs[0], 8'h10);
`ifdef CTRL_LDI_EN
    lit("r1_ldi", env_regs[1], 8'h5A);
    lit("r2_keep", env_regs[2], 8'h33);
`else
    lit("r1_keep", env_regs[1], 8'h20);
    lit("r2_xor", env_regs[2], 8'h00);
`endif
    lit("pc_final", env_pc, 8'h04);
    lit("halted", {7'b0, halted}, 8'h01);

    // Randomized programs with random ack delays and reset inside EXEC.
    ack_always = 1'b0;
    for (int ep = 0; ep < 30; ep++) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] = 8'($urandom);
        if (mem[i][7:4] == 4'hF && $urandom_range(0, 3) != 0)
          mem[i][7:4] = 4'h8;
      end
      for (int i = 0; i < 4; i++)
        seed[i] = 8'($urandom);
      do_reset();
      rst_at = (ep % 3 == 0) ? int'($urandom_range(0, 15)) : 1000;
      code = 0;
      n    = 0;
      while (code == 0 && n < 40) begin
        minstr(n >= rst_at, code);
        n++;
      end
      if (code == 1)
        repeat (5) cyc(HLT_V, rnd_ack());
    end

    chk_en = 1'b0;
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
